// File: rtl/slc3_pkg.sv
// rtl/slc3_pkg.sv - shared SLC-3 memory arbiter types and owner encodings
package slc3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - arb_pick grant select; MEM_ARB_RR_EN gives round-robin ties, else CPU priority
module arb_pick
    import slc3_pkg::*;
(
    input  logic cpu_req_i,
    input  logic dbg_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_owner_i,
`endif
    output logic gnt_valid_o,
    output logic gnt_owner_o
);

    always_comb begin
        gnt_valid_o = cpu_req_i | dbg_req_i;
`ifdef MEM_ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        if (cpu_req_i && dbg_req_i) begin
            gnt_owner_o = ~last_owner_i;
        end else begin
            gnt_owner_o = dbg_req_i ? OWNER_DBG : OWNER_CPU;
        end
`else
        gnt_owner_o = cpu_req_i ? OWNER_CPU : OWNER_DBG;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/debug arbiter for the single SLC-3 memory port; MEM_ARB_RR_EN enables round-robin
module mem_arbiter
    import slc3_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_ack_o,
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o,
    output logic                  dbg_ack_o,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_mem_ena,
    output logic                  mem_wr_ena,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy_o,
    output logic                  owner_o
);

    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
        $error("mem_arbiter: RD_LATENCY must be in 1..7");
    end
    if (WR_LATENCY < 0 || WR_LATENCY > 7) begin : g_bad_wr_latency
        $error("mem_arbiter: WR_LATENCY must be in 0..7");
    end

    localparam logic [LAT_CNT_W-1:0] RD_LAT = LAT_CNT_W'(RD_LATENCY);
    localparam logic [LAT_CNT_W-1:0] WR_LAT = LAT_CNT_W'(WR_LATENCY);

    arb_state_t state_q, state_d;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  owner_q, owner_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  cpu_armed_q, cpu_armed_d;
    logic                  dbg_armed_q, dbg_armed_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

    logic                  gnt_valid;
    logic                  gnt_owner;
    logic                  grant;
    logic [LAT_CNT_W-1:0]  issue_lat;
    logic                  rd_capture;

`ifdef MEM_ARB_RR_EN
    logic last_owner_q, last_owner_d;
`endif

    arb_pick u_pick (
        .cpu_req_i    (cpu_req_i & cpu_armed_q),
        .dbg_req_i    (dbg_req_i & dbg_armed_q),
`ifdef MEM_ARB_RR_EN
        .last_owner_i (last_owner_q),
`endif
        .gnt_valid_o  (gnt_valid),
        .gnt_owner_o  (gnt_owner)
    );

    assign grant      = (state_q == IDLE) && gnt_valid;
    assign issue_lat  = we_q ? WR_LAT : RD_LAT;
    // mem_rdata is valid exactly RD_LATENCY cycles after the strobe, i.e. the last WAIT cycle.
    assign rd_capture = (state_q == WAIT) && !we_q && (cnt_q == LAT_CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = ISSUE;
            ISSUE:   state_d = (issue_lat != '0) ? WAIT : ACK;
            WAIT:    if (cnt_q <= LAT_CNT_W'(1)) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_mem_ena = (state_q == ISSUE);
        mem_wr_ena  = (state_q == ISSUE) && we_q;
        busy_o      = (state_q != IDLE);
        cpu_ack_o   = (state_q == ACK) && (owner_q == OWNER_CPU);
        dbg_ack_o   = (state_q == ACK) && (owner_q == OWNER_DBG);
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        owner_o     = owner_q;
        cpu_rdata_o = cpu_rdata_q;
        dbg_rdata_o = dbg_rdata_q;
    end

    always_comb begin
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        cpu_armed_d = cpu_armed_q;
        dbg_armed_d = dbg_armed_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        if (grant) begin
            owner_d = gnt_owner;
            if (gnt_owner == OWNER_CPU) begin
                we_d        = cpu_we_i;
                addr_d      = cpu_addr_i;
                wdata_d     = cpu_wdata_i;
                cpu_armed_d = 1'b0;
            end else begin
                we_d        = dbg_we_i;
                addr_d      = dbg_addr_i;
                wdata_d     = dbg_wdata_i;
                dbg_armed_d = 1'b0;
            end
        end

        // A low request re-arms; a request held high after its ack stays disarmed.
        if (!cpu_req_i) cpu_armed_d = 1'b1;
        if (!dbg_req_i) dbg_armed_d = 1'b1;

        if (state_q == ISSUE) begin
            cnt_d = issue_lat;
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
        end

        if (rd_capture) begin
            if (owner_q == OWNER_CPU) cpu_rdata_d = mem_rdata;
            else                      dbg_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= OWNER_CPU;
            cnt_q       <= '0;
            cpu_armed_q <= 1'b1;
            dbg_armed_q <= 1'b1;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            cpu_armed_q <= cpu_armed_d;
            dbg_armed_q <= dbg_armed_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        last_owner_d = last_owner_q;
        if (grant) last_owner_d = gnt_owner;
    end

    // Starts at DBG so the CPU takes the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWNER_DBG;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

endmodule
